// File: rtl/to_upper.sv
// Registered ASCII lowercase-to-uppercase converter with a saturating count of
// converted bytes. One byte per cycle, one cycle of latency, no backpressure.
module to_upper #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A0,
    input  logic             A1,
    input  logic             A2,
    input  logic             A3,
    input  logic             A4,
    input  logic             A5,
    input  logic             A6,
    input  logic             A7,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic             B0,
    output logic             B1,
    output logic             B2,
    output logic             B3,
    output logic             B4,
    output logic             B5,
    output logic             B6,
    output logic             B7,
    output logic             out_valid,
    output logic             converted,
    output logic [CNT_W-1:0] conv_count
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [7:0]       a_byte;
    logic             is_lower;
    logic [7:0]       b_d, b_q;
    logic             valid_d, valid_q;
    logic             conv_d, conv_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign a_byte = {A7, A6, A5, A4, A3, A2, A1, A0};

    // MSB check keeps 0xE1..0xFA from matching on their low seven bits.
    assign is_lower = !a_byte[7] && (a_byte >= 8'h61) && (a_byte <= 8'h7A);

    always_comb begin
        b_d     = b_q;
        valid_d = 1'b0;
        conv_d  = 1'b0;
        cnt_d   = cnt_q;
        // A is only looked at under in_valid so garbage on idle cycles is ignored.
        if (in_valid) begin
            valid_d = 1'b1;
            conv_d  = is_lower;
            b_d     = is_lower ? {a_byte[7:6], 1'b0, a_byte[4:0]} : a_byte;
            if (is_lower && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + CntOne;
            end
        end
        // Clear takes priority over a same-cycle conversion.
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q     <= 8'h00;
            valid_q <= 1'b0;
            conv_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            b_q     <= b_d;
            valid_q <= valid_d;
            conv_q  <= conv_d;
            cnt_q   <= cnt_d;
        end
    end

    assign {B7, B6, B5, B4, B3, B2, B1, B0} = b_q;
    assign out_valid  = valid_q;
    assign converted  = conv_q;
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_to_upper.sv
// Scoreboard bench for to_upper: stimulus pushes expected results, a negedge
// monitor pops and compares whenever out_valid is high.
module tb_to_upper;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [7:0]       a_bus;
    logic             in_valid;
    logic             clr_cnt;
    logic [7:0]       b_bus;
    logic             out_valid;
    logic             converted;
    logic [CNT_W-1:0] conv_count;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] b;
        logic       conv;
        int         cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         model_cnt;
    logic [7:0] last_b;

    to_upper #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A0        (a_bus[0]),
        .A1        (a_bus[1]),
        .A2        (a_bus[2]),
        .A3        (a_bus[3]),
        .A4        (a_bus[4]),
        .A5        (a_bus[5]),
        .A6        (a_bus[6]),
        .A7        (a_bus[7]),
        .in_valid  (in_valid),
        .clr_cnt   (clr_cnt),
        .B0        (b_bus[0]),
        .B1        (b_bus[1]),
        .B2        (b_bus[2]),
        .B3        (b_bus[3]),
        .B4        (b_bus[4]),
        .B5        (b_bus[5]),
        .B6        (b_bus[6]),
        .B7        (b_bus[7]),
        .out_valid (out_valid),
        .converted (converted),
        .conv_count(conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ASCII lowercase letters map to uppercase, everything else is unchanged.
    function automatic logic ref_is_lower(input logic [7:0] a);
        return (a >= 8'h61) && (a <= 8'h7A);
    endfunction

    function automatic logic [7:0] ref_upper(input logic [7:0] a);
        return ref_is_lower(a) ? a - 8'h20 : a;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Drives one cycle of inputs; the DUT captures them at the next rising edge.
    task automatic drive(input logic v, input logic [7:0] a, input logic clr);
        exp_t e;
        @(posedge clk);
        #1;
        a_bus    = a;
        in_valid = v;
        clr_cnt  = clr;
        if (clr) model_cnt = 0;
        else if (v && ref_is_lower(a) && model_cnt < CMAX) model_cnt++;
        if (v) begin
            e.b    = ref_upper(a);
            e.conv = ref_is_lower(a);
            e.cnt  = model_cnt;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic check_count(input string name);
        @(negedge clk);
        check(name, int'(conv_count), model_cnt);
    endtask

    // Monitor: pops on each valid output, checks hold behaviour otherwise.
    initial begin
        exp_t e;
        last_b = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_b = 8'h00;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("b_byte", int'(b_bus), int'(e.b));
                    check("converted", int'(converted), int'(e.conv));
                    check("conv_count", int'(conv_count), e.cnt);
                    last_b = e.b;
                end
            end else begin
                check("b_hold", int'(b_bus), int'(last_b));
                check("converted_idle", int'(converted), 0);
            end
        end
    end

    logic [7:0] pass_bytes [16];
    logic [7:0] bound_bytes [5];

    initial begin
        pass_bytes = '{8'h28, 8'h48, 8'hB7, 8'h83, 8'h7C, 8'h14, 8'hEB, 8'h41,
                       8'h47, 8'h92, 8'h30, 8'hCF, 8'h3A, 8'h7B, 8'h94, 8'h7F};
        bound_bytes = '{8'h60, 8'h61, 8'h7A, 8'h7B, 8'hE1};
        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        a_bus     = 8'h00;
        in_valid  = 1'b0;
        clr_cnt   = 1'b0;
        rst_n     = 1'b1;

        // Reset asserted between edges must act immediately.
        #2 rst_n = 1'b0;
        #1;
        check("rst_b", int'(b_bus), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_count", int'(conv_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        @(negedge clk);
        check("post_rst_b", int'(b_bus), 0);
        check("post_rst_valid", int'(out_valid), 0);

        drive(1'b1, 8'h61, 1'b0);
        drive(1'b1, 8'h7A, 1'b0);
        drive(1'b1, 8'h6D, 1'b0);
        idle(1);
        check_count("lower_stream_count");

        foreach (pass_bytes[i]) drive(1'b1, pass_bytes[i], 1'b0);
        idle(1);
        check_count("pass_stream_count");

        foreach (bound_bytes[i]) drive(1'b1, bound_bytes[i], 1'b0);

        // Valid gap: B must hold 0x42 while idle bytes of 0x63 are ignored.
        drive(1'b1, 8'h62, 1'b0);
        drive(1'b0, 8'h63, 1'b0);
        drive(1'b0, 8'h63, 1'b0);
        idle(1);
        check_count("gap_count");

        // Saturation at 15, then clear racing a conversion.
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'h61 + 8'(i % 26), 1'b0);
        idle(1);
        check_count("saturated_count");
        drive(1'b1, 8'h61, 1'b1);
        idle(1);
        check_count("clear_wins_count");

        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h5E, 8'h7D)) : 8'($urandom);
            drive(($urandom_range(0, 9) < 7), a, ($urandom_range(0, 19) == 0));
        end
        idle(1);
        check_count("random_count");

        // Asynchronous reset mid-stream drops the in-flight byte.
        drive(1'b1, 8'h71, 1'b0);
        drive(1'b1, 8'h72, 1'b0);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check("mid_rst_b", int'(b_bus), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_conv", int'(converted), 0);
        check("mid_rst_count", int'(conv_count), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        @(negedge clk);
        check("after_mid_rst_valid", int'(out_valid), 0);
        check("leftover_expected", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/to_upper.md
Name: to_upper

Overview:
- Registered ASCII case converter.
- Each valid input byte that is a lowercase letter ('a'..'z', 0x61..0x7A) is converted to its uppercase form.
- Every other byte, including control codes, punctuation, digits, uppercase letters, DEL and all bytes 0x80..0xFF, passes through unchanged.
- Sits in the character datapath between the byte source and downstream text consumers; it also keeps a running count of conversions for status readout.

Parameters:
- CNT_W, 16, width of the saturating conversion counter.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- A0..A7  input  1 each  input byte, A0 = LSB, A7 = MSB
- in_valid  input  1  input byte qualifier; byte is sampled only when high
- clr_cnt  input  1  synchronous clear of conv_count
- B0..B7  output  1 each  converted byte, B0 = LSB, B7 = MSB, registered
- out_valid  output  1  B0..B7 hold a fresh result for this cycle
- converted  output  1  the current output byte was changed, i.e. the input was 'a'..'z'
- conv_count  output  CNT_W  number of bytes converted since reset or clear, saturating

Behaviour:
- Reset: asynchronous on rst_n low.
  - B0..B7 = 0x00, out_valid = 0, converted = 0, conv_count = 0.
  - Outputs hold these values until the first clk rise after rst_n deasserts.
- Conversion function, with A = {A7..A0}:
  - if 0x61 <= A <= 0x7A then B = A with bit 5 cleared (A - 0x20); else B = A.
  - Bounds are inclusive; 0x60 '`' and 0x7B '{' are not converted.
  - Bytes with A7 = 1 are never converted, even if their low 7 bits match a lowercase code.
- Latency: exactly 1 cycle.
  - On a clk rise with in_valid = 1: B <= f(A), converted <= (A in range), out_valid <= 1.
  - On a clk rise with in_valid = 0: out_valid <= 0, converted <= 0, and B0..B7 hold the previous value (no glitch to 0).
- Throughput: one byte per cycle; back-to-back valid bytes are supported with no bubbles. No backpressure.
- conv_count:
  - Increments by 1 on each clk rise where in_valid = 1 and A is in range.
  - Saturates at 2^CNT_W - 1 and never wraps.
- clr_cnt:
  - On a clk rise with clr_cnt = 1, conv_count <= 0.
  - If a conversion occurs in the same cycle, clear wins: the count is 0, not 1.
  - clr_cnt does not affect B, out_valid or converted.
- Reset mid-stream: any in-flight byte is discarded, and all outputs return to reset values immediately without waiting for clk.
- Inputs are sampled only at the clk edge; X on A while in_valid = 0 must not corrupt outputs or the counter.

Test Plan:
- Reset check: assert rst_n = 0 between clock edges -> B = 0x00, out_valid = 0, conv_count = 0 immediately; release, then idle 3 cycles -> still 0x00 and out_valid = 0.
- Lowercase stream: in_valid = 1, bytes 0x61, 0x7A, 0x6D back-to-back -> one cycle later B = 0x41, 0x5A, 0x4D on consecutive cycles; converted = 1 each time; conv_count = 3.
- Pass-through stream: 0x28, 0x48, 0xB7, 0x83, 0x7C, 0x14, 0xEB, 0x41, 0x47, 0x92, 0x30, 0xCF, 0x3A, 0x7B, 0x94, 0x7F -> B equals the input each cycle; converted = 0; conv_count unchanged.
- Boundaries: 0x60 -> 0x60; 0x61 -> 0x41; 0x7A -> 0x5A; 0x7B -> 0x7B; 0xE1 -> 0xE1 (MSB set, not converted).
- Valid gap: 0x62 with in_valid = 1, then 2 cycles with in_valid = 0 and A = 0x63 -> B = 0x42 and holds; out_valid is 1, 0, 0; conv_count increments once only.
- Counter: with CNT_W = 4, feed 20 lowercase bytes -> conv_count stops at 15. Then assert clr_cnt together with a valid 0x61 -> conv_count = 0 and B = 0x41. Pulse rst_n low mid-stream -> all outputs 0 asynchronously.
